// File: rtl/result_serializer.sv
// Result serializer: FIFO-buffered {coordinate, mad} words shifted out MSB-first behind a start bit.
// Optional feature: define SERIAL_PARITY_EN to append an even-parity bit to every frame.
module result_serializer #(
    parameter int COORD_W = 8,
    parameter int MAD_W   = 12,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COORD_W-1:0]         coordinate,
    input  logic [MAD_W-1:0]           mad,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       s_out_port,
    output logic                       s_out_valid,
    output logic                       frame_done,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int W  = COORD_W + MAD_W;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA
`ifdef SERIAL_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_shift;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic          r_port;
    logic          r_valid;
    logic          r_done;
`ifdef SERIAL_PARITY_EN
    logic          r_par;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_last;
    logic [W-1:0]  w_head;

    assign in_ready    = !rst && (r_level != LW'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_head      = r_mem[r_rptr];
`ifdef SERIAL_PARITY_EN
    assign w_last      = (r_state == S_PARITY);
`else
    assign w_last      = (r_state == S_DATA) && (r_cnt == '0);
`endif
    // Popping only from a non-empty FIFO guarantees a fresh push is never bypassed.
    assign w_pop       = (r_level != '0) && ((r_state == S_IDLE) || w_last);

    assign s_out_port  = r_port;
    assign s_out_valid = r_valid;
    assign frame_done  = r_done;
    assign level       = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {coordinate, mad};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_port  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_state <= S_START;
                r_shift <= w_head;
                r_port  <= 1'b1;
                r_valid <= 1'b1;
`ifdef SERIAL_PARITY_EN
                r_par   <= ^w_head;
`endif
            end else if ((r_state == S_IDLE) || w_last) begin
                r_state <= S_IDLE;
                r_port  <= 1'b0;
                r_valid <= 1'b0;
            end else if (r_state == S_START) begin
                r_state <= S_DATA;
                r_cnt   <= CW'(W - 1);
                r_port  <= r_shift[W-1];
                r_shift <= r_shift << 1;
            end else if (r_cnt != '0) begin
                // r_cnt tracks the index of the data bit currently on the pin.
                r_cnt   <= r_cnt - 1'b1;
                r_port  <= r_shift[W-1];
                r_shift <= r_shift << 1;
`ifndef SERIAL_PARITY_EN
                r_done  <= (r_cnt == CW'(1));
`endif
            end
`ifdef SERIAL_PARITY_EN
            else begin
                r_state <= S_PARITY;
                r_port  <= r_par;
                r_done  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Testbench for result_serializer: directed scenarios plus randomized traffic against a frame-level queue model.
module tb_result_serializer;

    localparam int COORD_W = 8;
    localparam int MAD_W   = 12;
    localparam int DEPTH   = 4;
    localparam int W       = COORD_W + MAD_W;
    localparam int LW      = $clog2(DEPTH + 1);
`ifdef SERIAL_PARITY_EN
    localparam int F = W + 2;
`else
    localparam int F = W + 1;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [COORD_W-1:0] coordinate;
    logic [MAD_W-1:0]   mad;
    logic               in_valid;
    logic               in_ready;
    logic               s_out_port;
    logic               s_out_valid;
    logic               frame_done;
    logic [LW-1:0]      level;

    always #5 clk = ~clk;

    result_serializer #(.COORD_W(COORD_W), .MAD_W(MAD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .coordinate(coordinate), .mad(mad),
        .in_valid(in_valid), .in_ready(in_ready), .s_out_port(s_out_port),
        .s_out_valid(s_out_valid), .frame_done(frame_done), .level(level)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queued words plus the frame currently on the pin (idx = bit position, -1 idle)
    logic [W-1:0] q[$];
    logic [W-1:0] cur;
    int           idx = -1;

    logic [63:0] cap;
    int          ncap, run, maxrun;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic fbit(input logic [W-1:0] w, input int i);
        if (i == 0) return 1'b1;
        if (i <= W) return w[W-i];
        return ^w;
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [W-1:0] w);
        logic acc;
        logic exp_port;
        rst        = r;
        in_valid   = v;
        coordinate = w[W-1:MAD_W];
        mad        = w[MAD_W-1:0];
        #1;
        chk("in_ready", in_ready, !r && (q.size() != DEPTH));
        acc = v && !r && (q.size() != DEPTH);
        @(posedge clk);
        if (r) begin
            q.delete();
            idx = -1;
        end else begin
            if (idx < 0 || idx == F - 1) begin
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    idx = 0;
                end else begin
                    idx = -1;
                end
            end else begin
                idx++;
            end
            if (acc) q.push_back(w);
        end
        #1;
        exp_port = (idx >= 0) ? fbit(cur, idx) : 1'b0;
        chk("s_out_valid", s_out_valid, idx >= 0);
        chk("s_out_port", s_out_port, exp_port);
        chk("frame_done", frame_done, idx == F - 1);
        chk("level", level, q.size());
        if (s_out_valid === 1'b1) begin
            cap = {cap[62:0], s_out_port};
            ncap++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [W-1:0] wd;
        int           pct;
        int           guard;
        rst = 1'b1; in_valid = 1'b0; coordinate = '0; mad = '0;
        cap = '0; ncap = 0; run = 0; maxrun = 0;

        repeat (3) cycle(1'b1, 1'b0, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        idle(2);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Single word with known frame
        cap = '0; ncap = 0;
        cycle(1'b0, 1'b1, {8'hA5, 12'h3C1});
        idle(F + 3);
        chk("single_len", ncap, F);
`ifdef SERIAL_PARITY_EN
        chk("single_bits", cap[31:0], 32'h0034_A783);
`else
        chk("single_bits", cap[31:0], 32'h001A_53C1);
`endif

        cap = '0; ncap = 0;
        cycle(1'b0, 1'b1, 20'h00003);
        idle(F + 3);
`ifdef SERIAL_PARITY_EN
        chk("low_bits", cap[31:0], 32'h0020_0006);
`else
        chk("low_bits", cap[31:0], 32'h0010_0003);
`endif

        // Back-to-back frames
        maxrun = 0; run = 0;
        cycle(1'b0, 1'b1, 20'hFFFFF);
        cycle(1'b0, 1'b1, 20'h00000);
        idle(2 * F + 3);
        chk("b2b_run", maxrun, 2 * F);

        // Backpressure
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, W'(32'h1_1111 * (k + 1) + 32'h7));
        chk("bp_level", level, 4);
        chk("bp_ready", in_ready, 1'b0);
        idle(5 * F + 5);

        // Push on the cycle a frame ends, with two words queued
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, W'(32'hC0DE0 + k));
        guard = 0;
        while (idx != F - 1 && guard < 2 * F) begin
            cycle(1'b0, 1'b0, '0);
            guard++;
        end
        chk("sim_wait", idx == F - 1, 1'b1);
        cycle(1'b0, 1'b1, 20'hBEEF5);
        chk("sim_level", level, 2);
        idle(4 * F + 5);

        // Reset in the middle of a frame with three words queued
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, W'(32'h5A5A0 + k));
        chk("rm_queued", level, 3);
        guard = 0;
        while (idx != W - 10 && guard < 2 * F) begin
            cycle(1'b0, 1'b0, '0);
            guard++;
        end
        chk("rm_wait", idx == W - 10, 1'b1);
        cycle(1'b1, 1'b0, '0);
        chk("rm_valid", s_out_valid, 1'b0);
        chk("rm_port", s_out_port, 1'b0);
        chk("rm_done", frame_done, 1'b0);
        chk("rm_level", level, 0);
        cap = '0; ncap = 0;
        cycle(1'b0, 1'b1, {8'hA5, 12'h3C1});
        idle(F + 3);
        chk("rm_refr_len", ncap, F);
`ifdef SERIAL_PARITY_EN
        chk("rm_refr_bits", cap[31:0], 32'h0034_A783);
`else
        chk("rm_refr_bits", cap[31:0], 32'h001A_53C1);
`endif

        // Randomized traffic with varying load and occasional reset
        pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pct = $urandom_range(0, 100);
            wd = W'($urandom);
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pct, wd);
        end
        idle(DEPTH * F + F + 5);
        chk("final_level", level, 0);
        chk("final_valid", s_out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
# result_serializer

Parametrised output stage for the full-search block-matching array: buffers (coordinate, MAD) result pairs in a small FIFO and shifts each out MSB-first on a single serial pin, framed by a start bit. It sits between the minimum-MAD comparator and the chip output pad. It is the next generation of the 20-bit output register, adding configurable field widths, queueing depth, flow control and explicit frame signalling.

## Interface
- COORD_W, 8, width of the motion-vector coordinate field
- MAD_W, 12, width of the MAD field; word width W = COORD_W + MAD_W
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- coordinate  input  COORD_W  coordinate of the best match
- mad  input  MAD_W  MAD of the best match
- in_valid  input  1  result pair present
- in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at rising edge
- s_out_port  output  1  registered serial data
- s_out_valid  output  1  registered; high for every bit time of a frame
- frame_done  output  1  registered one-cycle pulse coincident with the last bit of a frame
- level  output  $clog2(DEPTH+1)  words held in FIFO, excluding the word being shifted

## Operation
- Word = {coordinate, mad}; coordinate occupies the MSBs.
- in_ready = !rst && (level != DEPTH). It is combinational from registered state and does not depend on in_valid.
- A push while full is impossible: in_ready blocks it, even when a pop occurs in the same cycle.
- FSM states:
  - IDLE: s_out_port=0, s_out_valid=0.
  - START: bit = 1.
  - DATA: W bits, MSB first, down-counter from W-1 to 0.
  - PARITY: present only with the macro.
- IDLE→START when level != 0. On that edge the FIFO head is popped into the shift register.
- Leaving the last bit state (DATA at count 0, or PARITY):
  - level != 0: go to START and pop the next word on the same edge, so back-to-back frames have no idle gap.
  - level == 0: go to IDLE.
- Simultaneous push and pop in one cycle: level is unchanged and both take effect.
- A push into an empty FIFO is never bypassed to the shifter; it always passes through one FIFO stage.
- The FIFO pointers wrap modulo DEPTH.
- Reset mid-frame: the frame is aborted and the FIFO is emptied. The next cycle shows s_out_port=0, s_out_valid=0, frame_done=0, level=0, state IDLE.

## Timing
- Reset values: s_out_port=0, s_out_valid=0, frame_done=0, level=0, in_ready=0 while rst is high and 1 the cycle after rst falls.
- Word accepted at edge E0 into an empty, idle block:
  - level=1 after E0.
  - At E1 the word is popped (level=0) and the start bit is driven.
  - Data bit W-1-k is driven after edge E2+k.
  - The last data bit is after E(W+1), with frame_done=1.
- Frame length F = W+1 cycles without parity, W+2 with parity.
- Sustained throughput: one word per F cycles.
- Latency from acceptance to start bit: 1 cycle when idle. Otherwise the start bit follows the current frame's last bit directly.

## Configuration
- SERIAL_PARITY_EN defined:
  - A PARITY state follows DATA and drives the XOR of all W word bits (even parity).
  - frame_done moves to the parity bit, and F = W+2.
- Undefined: no PARITY state, F = W+1, and frame_done is on the LSB.

## Test plan
- Single word, defaults: coordinate=8'hA5, mad=12'h3C1, one push after reset → serial sequence 1, then 1010_0101_0011_1100_0001; s_out_valid high 21 cycles; frame_done on the final 1; then s_out_port=0.
- Back-to-back: push 20'hFFFFF and 20'h00000 on consecutive cycles → start bit of the second frame immediately follows the last bit of the first frame; 42 contiguous s_out_valid cycles.
- Backpressure: hold in_valid=1 with distinct words for 10 cycles → in_ready drops after the 5th acceptance (1 shifting + 4 queued); level=4; all accepted words emerge in order; none duplicated or lost.
- Simultaneous push and pop: with level=2, push on the cycle a frame ends → level stays 2; order is preserved.
- Reset mid-frame: assert rst during data bit 10 of a frame with 3 words queued → next cycle all outputs 0 and level=0; after release, a new push frames correctly.
- With SERIAL_PARITY_EN, word 20'hA53C1 (nine ones) → 22-bit frame ending with parity bit 1 and frame_done on it; word 20'h00003 → parity 0.
